// File: rtl/alu.sv
// Single-cycle registered ALU with RISC-V style fn/funct7 decode.
// Optional `ALU_FLAGS_EN adds registered zero/neg/carry/ovf outputs.

package alu_fns;
   typedef enum logic [2:0] {
      FN_ADD_SUB = 3'b000,
      FN_SLL     = 3'b001,
      FN_SLT     = 3'b010,
      FN_SLTU    = 3'b011,
      FN_XOR     = 3'b100,
      FN_SRL_SRA = 3'b101,
      FN_OR      = 3'b110,
      FN_AND     = 3'b111
   } alu_fn_t;

   typedef enum logic [6:0] {
      F7_ADD_SRL = 7'h00,
      F7_SUB_SRA = 7'h20
   } funct7_t;
endpackage

module alu
   import alu_fns::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [2:0]       fn,
   input  logic [6:0]       funct7,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
`ifdef ALU_FLAGS_EN
   ,
   output logic             zero,
   output logic             neg,
   output logic             carry,
   output logic             ovf
`endif
);

   localparam int unsigned SHW = $clog2(WIDTH);

   alu_fn_t          op_c;
   logic             alt_c;
   logic [SHW-1:0]   shamt_c;
   logic [WIDTH-1:0] b_op_c;
   logic [WIDTH-1:0] sra_c;
   logic [WIDTH-1:0] res_c;

   assign op_c    = alu_fn_t'(fn);
   assign alt_c   = (funct7 != 7'h00);
   assign shamt_c = b[SHW-1:0];
   assign b_op_c  = alt_c ? ~b : b;
   // kept as its own signal so the arithmetic shift stays signed
   assign sra_c   = $signed(a) >>> shamt_c;

   // subtract is a + ~b + 1; carry-out of that sum is the no-borrow flag
`ifdef ALU_FLAGS_EN
   logic [WIDTH:0]   sum_c;
   logic             is_addsub_c;
   logic             ovf_c;
   assign sum_c       = {1'b0, a} + {1'b0, b_op_c} + (WIDTH+1)'(alt_c);
   assign is_addsub_c = (op_c == FN_ADD_SUB);
   assign ovf_c       = (a[WIDTH-1] == b_op_c[WIDTH-1]) &&
                        (sum_c[WIDTH-1] != a[WIDTH-1]);
`else
   logic [WIDTH-1:0] sum_c;
   assign sum_c = a + b_op_c + WIDTH'(alt_c);
`endif

   always_comb begin
      res_c = '0;
      case (op_c)
         FN_ADD_SUB: res_c = sum_c[WIDTH-1:0];
         FN_SLL:     res_c = a << shamt_c;
         FN_SLT:     res_c = WIDTH'($signed(a) < $signed(b));
         FN_SLTU:    res_c = WIDTH'(a < b);
         FN_XOR:     res_c = a ^ b;
         FN_SRL_SRA: res_c = alt_c ? sra_c : (a >> shamt_c);
         FN_OR:      res_c = a | b;
         FN_AND:     res_c = a & b;
         default:    res_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out <= res_c;
         end
      end
   end

`ifdef ALU_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero  <= 1'b0;
         neg   <= 1'b0;
         carry <= 1'b0;
         ovf   <= 1'b0;
      end else if (in_valid) begin
         zero  <= (res_c == '0);
         neg   <= res_c[WIDTH-1];
         carry <= is_addsub_c & sum_c[WIDTH];
         ovf   <= is_addsub_c & ovf_c;
      end
   end
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed corner cases, mid-stream reset,
// then back-to-back random operations against an arithmetic reference model.

module tb_alu;
   import alu_fns::*;

   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid = 1'b0;
   logic [2:0]       fn = 3'd0;
   logic [6:0]       funct7 = 7'd0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic [WIDTH-1:0] out;
   logic             out_valid;
`ifdef ALU_FLAGS_EN
   logic             zero, neg, carry, ovf;
`endif

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        n;
      logic        c;
      logic        v;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   checks = 0;
   int   failures = 0;
   logic exp_valid;

   alu #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .fn        (fn),
      .funct7    (funct7),
      .a         (a),
      .b         (b),
      .out       (out),
      .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
      ,
      .zero      (zero),
      .neg       (neg),
      .carry     (carry),
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   // reference: results straight from the arithmetic definition of each fn
   function automatic exp_t model(input logic [2:0] f, input logic [6:0] f7,
                                  input logic [31:0] x, input logic [31:0] y);
      exp_t   e;
      int     sh;
      longint sx, sy, ss;
      longint unsigned ux, uy;
      sh = int'(y % 32);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = 64'(x);
      uy = 64'(y);
      e.res = 32'd0;
      e.c = 1'b0;
      e.v = 1'b0;
      case (f)
         FN_ADD_SUB: begin
            if (f7 == 7'h00) begin
               e.res = 32'(ux + uy);
               e.c   = (ux + uy) > 64'hFFFF_FFFF;
               ss    = sx + sy;
            end else begin
               e.res = 32'(ux - uy);
               e.c   = (ux >= uy);
               ss    = sx - sy;
            end
            e.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         FN_SLL:     e.res = x << sh;
         FN_SLT:     e.res = (sx < sy) ? 32'd1 : 32'd0;
         FN_SLTU:    e.res = (ux < uy) ? 32'd1 : 32'd0;
         FN_XOR:     e.res = x ^ y;
         FN_SRL_SRA: begin
            if (f7 == 7'h00 || x[31] == 1'b0) e.res = x >> sh;
            else                              e.res = ~((~x) >> sh);
         end
         FN_OR:      e.res = x | y;
         default:    e.res = x & y;
      endcase
      e.z = (e.res == 32'd0);
      e.n = e.res[31];
      return e;
   endfunction

   task automatic check_exp(input string name, input exp_t e);
      logic bad;
      checks++;
      bad = (out !== e.res);
`ifdef ALU_FLAGS_EN
      bad = bad || (zero !== e.z) || (neg !== e.n) || (carry !== e.c) || (ovf !== e.v);
      if (bad) begin
         failures++;
         $display("FAIL %s: out=%h znc v=%b%b%b%b want out=%h znc v=%b%b%b%b",
                  name, out, zero, neg, carry, ovf, e.res, e.z, e.n, e.c, e.v);
      end
`else
      if (bad) begin
         failures++;
         $display("FAIL %s: out=%h want %h", name, out, e.res);
      end
`endif
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // out_valid reference: in_valid seen at the previous edge, cleared by reset
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) exp_valid <= 1'b0;
      else        exp_valid <= in_valid;
   end

   // monitor: pops the scoreboard whenever the DUT presents a result
   always @(negedge clk) begin
      if (!rst_n) begin
         last = '{res: 32'd0, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0};
      end else begin
         check_val("out_valid", 32'(out_valid), 32'(exp_valid));
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_result: out=%h with empty scoreboard", out);
            end else begin
               last = sb.pop_front();
               check_exp("result", last);
            end
         end else begin
            check_exp("hold", last);
         end
      end
   end

   task automatic issue(input logic [2:0] f, input logic [6:0] f7,
                        input logic [31:0] x, input logic [31:0] y);
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      fn       = f;
      funct7   = f7;
      a        = x;
      b        = y;
      sb.push_back(model(f, f7, x, y));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         fn       = 3'($urandom);
         funct7   = 7'($urandom);
         a        = $urandom;
         b        = $urandom;
      end
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1 rst_n = 1'b0;
      #1;
      check_val("reset_out", out, 32'd0);
      check_val("reset_out_valid", 32'(out_valid), 32'd0);
      #11 rst_n = 1'b1;

      issue(FN_ADD_SUB, F7_ADD_SRL, 32'hFFFF_FFFF, 32'h0000_0001);
      issue(FN_ADD_SUB, F7_ADD_SRL, 32'hFFFF_FFFB, 32'h0000_0006);
      issue(FN_ADD_SUB, F7_SUB_SRA, 32'h0000_0005, 32'hFFFF_FFFA);
      issue(FN_ADD_SUB, F7_SUB_SRA, 32'hFFFF_FFFB, 32'h0000_0006);
      issue(FN_SRL_SRA, F7_ADD_SRL, 32'h8000_0000, 32'h0000_0024);
      issue(FN_SRL_SRA, F7_SUB_SRA, 32'h8000_0000, 32'h0000_0024);
      issue(FN_SLT,     F7_ADD_SRL, 32'hFFFF_FFFF, 32'h0000_0001);
      issue(FN_SLTU,    F7_ADD_SRL, 32'hFFFF_FFFF, 32'h0000_0001);
      issue(FN_SLL,     F7_ADD_SRL, 32'h0000_0001, 32'h0000_001F);
      issue(FN_SLL,     F7_SUB_SRA, 32'hA5A5_0F0F, 32'hFFFF_FFE0);
      issue(FN_SRL_SRA, F7_SUB_SRA, 32'h9000_0001, 32'h0000_0040);
      issue(FN_XOR,     F7_SUB_SRA, 32'hF0F0_1234, 32'h0FF0_4321);
      issue(FN_AND,     7'h7F,      32'hF0F0_1234, 32'h0FF0_4321);
      issue(FN_OR,      F7_SUB_SRA, 32'hF0F0_1234, 32'h0FF0_4321);
      idle(2);

      // asynchronous reset while out is nonzero, with an op pending
      issue(FN_OR, F7_ADD_SRL, 32'h0000_1200, 32'h0000_0034);
      @(posedge clk);
      #1;
      check_val("pre_reset_out", out, 32'h0000_1234);
      in_valid = 1'b1;
      fn       = FN_OR;
      a        = 32'hDEAD_BEEF;
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      check_val("async_reset_out", out, 32'd0);
      check_val("async_reset_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      rst_n    = 1'b1;
      idle(2);

      for (int i = 0; i < 10000; i++) begin
         logic [6:0] f7;
         f7 = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'h00;
         issue(3'($urandom), f7, rand_operand(), rand_operand());
      end
      idle(3);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d results never presented", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
